// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The fetch/decode side uses the master modport; the buffer itself uses slave.
interface if_id_buffer_if #(
  parameter int WORD_LEN = 16,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WORD_LEN-1:0] PCIn;
  logic [WORD_LEN-1:0] instructionIn;
  logic                fetchValid;
  logic                flush;
  logic                idFreeze;
  logic                freezeIF;
  logic [WORD_LEN-1:0] PCOut;
  logic [WORD_LEN-1:0] instructionOut;
  logic                idValid;
  logic [CNT_W-1:0]    count;

  modport master (
    output PCIn, instructionIn, fetchValid, flush, idFreeze,
    input  freezeIF, PCOut, instructionOut, idValid, count
  );

  modport slave (
    input  PCIn, instructionIn, fetchValid, flush, idFreeze,
    output freezeIF, PCOut, instructionOut, idValid, count
  );
endinterface

// File: rtl/if_id_buffer.sv
// Circular instruction queue between fetch and decode with first-word-fall-through head.
// Full/valid status comes only from the registered count, so a pop never frees a slot in the same cycle.
module if_id_buffer #(
  parameter int WORD_LEN = 16,
  parameter int DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  if_id_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_LEN-1:0] pcMem    [DEPTH];
  logic [WORD_LEN-1:0] instrMem [DEPTH];
  logic [PTR_W-1:0]    wrPtr;
  logic [PTR_W-1:0]    rdPtr;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                notEmpty;
  logic                push;
  logic                pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign notEmpty = (count != '0);
  assign push     = bus.fetchValid && !full && !bus.flush;
  assign pop      = notEmpty && !bus.idFreeze && !bus.flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is never cleared; the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pcMem[wrPtr]    <= bus.PCIn;
      instrMem[wrPtr] <= bus.instructionIn;
    end
  end

  assign bus.freezeIF       = full;
  assign bus.idValid        = notEmpty;
  assign bus.count          = count;
  assign bus.PCOut          = notEmpty ? pcMem[rdPtr]    : '0;
  assign bus.instructionOut = notEmpty ? instrMem[rdPtr] : '0;
endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter WORD_LEN, default 16, meaning the width of PC and instruction words.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port PCIn  input  WORD_LEN  PC of the fetched instruction from the fetch stage.
REQ-006 SHALL have port instructionIn  input  WORD_LEN  fetched instruction word.
REQ-007 SHALL have port fetchValid  input  1  PCIn/instructionIn are valid this cycle.
REQ-008 SHALL have port flush  input  1  branch taken; discard all queued and incoming instructions.
REQ-009 SHALL have port idFreeze  input  1  decode stage stalled; do not pop.
REQ-010 SHALL have port freezeIF  output  1  queue full; fetch stage must hold its PC.
REQ-011 SHALL have port PCOut  output  WORD_LEN  PC of the head entry.
REQ-012 SHALL have port instructionOut  output  WORD_LEN  head instruction, or 0 (NOP) when invalid.
REQ-013 SHALL have port idValid  output  1  head entry valid.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL implement a circular FIFO of DEPTH entries, each holding {PC, instruction}, with write pointer wrPtr, read pointer rdPtr and occupancy count.
REQ-016 SHALL drive freezeIF = (count == DEPTH) combinationally from registered count only.
REQ-017 SHALL drive idValid = (count != 0), also from registered count only.
REQ-018 SHALL push when fetchValid && !freezeIF && !flush: write entry at wrPtr, then wrPtr+1 modulo DEPTH.
REQ-019 SHALL pop when idValid && !idFreeze && !flush: rdPtr+1 modulo DEPTH.
REQ-020 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 SHALL present the head entry first-word-fall-through: PCOut/instructionOut = entry[rdPtr] when idValid, else PCOut = 0 and instructionOut = 0.
REQ-022 SHALL give one-cycle latency from push to visibility; no combinational bypass from instructionIn to instructionOut.
REQ-023 SHALL, when full, ignore fetchValid even if a pop occurs in the same cycle (freezeIF is from registered state); the push completes in the next cycle.
REQ-024 SHALL, on flush, set count=0, wrPtr=0 and rdPtr=0 at the next edge, discarding any same-cycle push; flush overrides push, pop and idFreeze.
REQ-025 SHALL ignore fetchValid when freezeIF is high, with no state change from it.
REQ-026 SHALL never underflow or overflow; count stays within 0..DEPTH under all input combinations.

Reset
REQ-027 SHALL, on rst high at a clock edge, set count=0, wrPtr=0, rdPtr=0, freezeIF=0, idValid=0, PCOut=0 and instructionOut=0.
REQ-028 SHALL give rst priority over flush, push and pop, and SHALL restore reset state even when asserted mid-operation.
REQ-029 SHALL not require entry storage to be cleared on reset, since outputs are masked by idValid.

Verification
REQ-030 SHALL cover single pass: reset, then push PC=0x0000, instr=0x1234 with idFreeze=1 -> next cycle idValid=1, instructionOut=0x1234, count=1.
REQ-031 SHALL cover fill and freeze: idFreeze=1, push PCs 0,4,8,12 -> count=4, freezeIF=1; a fifth push of PC=16 is ignored and count stays 4.
REQ-032 SHALL cover full with pop: from full, release idFreeze while fetchValid=1 for one cycle -> PC 0 popped, count=3, no push that cycle; next cycle PC=16 is accepted and count=4.
REQ-033 SHALL cover flush: with 3 entries and a simultaneous push, assert flush -> next cycle count=0, idValid=0, instructionOut=0, and the pushed word never appears.
REQ-034 SHALL cover wrap-around: stream 10 instructions with continuous push and pop -> PCOut sequence matches input order across pointer wrap, and count stays 1 in steady state.
REQ-035 SHALL cover reset mid-operation: rst asserted with count=2 and flush=1 -> next cycle all outputs 0 and freezeIF=0.
